// File: rtl/tvbg_pkg.sv
// tvbg_pkg: shared state encoding and constants for the tv_b_gone session sequencer
package tvbg_pkg;
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    WAIT_BUSY = 3'd2,
    RUN       = 3'd3,
    GAP       = 3'd4,
    ABORT     = 3'd5,
    ERROR     = 3'd6
  } state_t;
  localparam int ABORT_RESET_CYCLES = 2;
  localparam int PASS_W = 4;
endpackage

// File: rtl/tvbg_debounce.sv
// tvbg_debounce: button synchronizer, debounce filter and press pulse
module tvbg_debounce #(
  parameter int DEBOUNCE_CYCLES = 80000
) (
  input  logic clock_in,
  input  logic reset_in,
  input  logic button_n_in,
  output logic pressed_out,
  output logic press_out
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [1:0] sync;
  logic level;
  logic prev;
  logic [CW-1:0] cnt;
  assign level = ~sync[1];
  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      sync        <= 2'b11;
      cnt         <= '0;
      pressed_out <= 1'b0;
      prev        <= 1'b0;
      press_out   <= 1'b0;
    end else begin
      sync      <= {sync[0], button_n_in};
      prev      <= pressed_out;
      press_out <= pressed_out & ~prev;
      if (level == pressed_out)
        cnt <= '0;
      else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        pressed_out <= level;
        cnt         <= '0;
      end else
        cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/tvbg_sequencer.sv
// tvbg_sequencer: button-driven session controller that sequences, retries and aborts tv_b_gone core passes
module tvbg_sequencer
  import tvbg_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES      = 80000,
  parameter int REPEAT_COUNT         = 2,
  parameter int GAP_CYCLES           = 800000,
  parameter int MAX_RETRY            = 1,
  parameter int START_TIMEOUT_CYCLES = 16
) (
  input  logic              clock_in,
  input  logic              reset_in,
  input  logic              button_n_in,
  output logic              core_start_out,
  output logic              core_reset_out,
  input  logic              core_busy_in,
  input  logic              core_fail_in,
  output logic              active_led_out,
  output logic              fail_led_out,
  output logic [2:0]        state_out,
  output logic [PASS_W-1:0] pass_out
);
  localparam int TW = $clog2(START_TIMEOUT_CYCLES + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam int RW = MAX_RETRY > 0 ? $clog2(MAX_RETRY + 1) : 1;
  localparam int AW = $clog2(ABORT_RESET_CYCLES + 1);
  state_t state, nx;
  logic pressed, press_pulse, press;
  logic [PASS_W-1:0] pass_cnt;
  logic [RW-1:0] retry;
  logic [TW-1:0] tmo;
  logic [GW-1:0] gap;
  logic [AW-1:0] abort_cnt;
  logic abort_fail, fail_evt, ok_evt, run_fault, can_retry, last_pass, idle_press;
  tvbg_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
    .clock_in    (clock_in),
    .reset_in    (reset_in),
    .button_n_in (button_n_in),
    .pressed_out (pressed),
    .press_out   (press_pulse)
  );
  assign press      = press_pulse & pressed;
  assign can_retry  = int'(retry) < MAX_RETRY;
  assign last_pass  = int'(pass_cnt) + 1 >= REPEAT_COUNT;
  assign run_fault  = state == RUN && !press && core_busy_in && core_fail_in;
  assign idle_press = (state == IDLE || state == ERROR) && nx == START;
  assign state_out  = state;
  assign pass_out   = pass_cnt;
  // press takes priority over every core event so a second press always aborts
  always_comb begin
    nx       = state;
    fail_evt = 1'b0;
    ok_evt   = 1'b0;
    case (state)
      IDLE, ERROR: nx = press ? START : state;
      START:       nx = press ? ABORT : WAIT_BUSY;
      WAIT_BUSY: begin
        if (press) nx = ABORT;
        else if (core_busy_in) nx = RUN;
        else fail_evt = tmo == '0;
      end
      RUN: begin
        if (press || core_busy_in && core_fail_in) nx = ABORT;
        else if (!core_busy_in) begin
          fail_evt = core_fail_in;
          ok_evt   = !core_fail_in;
        end
      end
      GAP:     nx = press ? ABORT : gap == '0 ? START : GAP;
      ABORT:   nx = abort_cnt == '0 ? (abort_fail ? ERROR : IDLE) : ABORT;
      default: nx = IDLE;
    endcase
    if (fail_evt) nx = can_retry ? GAP : ERROR;
    if (ok_evt) nx = last_pass ? IDLE : GAP;
  end
  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      state          <= IDLE;
      pass_cnt       <= '0;
      retry          <= '0;
      tmo            <= '0;
      gap            <= '0;
      abort_cnt      <= '0;
      abort_fail     <= 1'b0;
      core_start_out <= 1'b0;
      core_reset_out <= 1'b0;
      active_led_out <= 1'b0;
      fail_led_out   <= 1'b0;
    end else begin
      state          <= nx;
      core_start_out <= nx == START;
      core_reset_out <= nx == ABORT;
      active_led_out <= state != IDLE && state != ERROR;
      tmo            <= nx == WAIT_BUSY && state != WAIT_BUSY ? TW'(START_TIMEOUT_CYCLES - 1) :
                        tmo != '0 ? tmo - 1'b1 : tmo;
      gap            <= nx == GAP && state != GAP ? GW'(GAP_CYCLES - 1) :
                        gap != '0 ? gap - 1'b1 : gap;
      abort_cnt      <= nx == ABORT && state != ABORT ? AW'(ABORT_RESET_CYCLES - 1) :
                        abort_cnt != '0 ? abort_cnt - 1'b1 : abort_cnt;
      if (nx == ABORT && state != ABORT) abort_fail <= run_fault;
      if (idle_press) begin
        fail_led_out <= 1'b0;
        pass_cnt     <= '0;
        retry        <= '0;
      end else begin
        if (nx == ERROR && state != ERROR) fail_led_out <= 1'b1;
        if (ok_evt) begin
          pass_cnt <= pass_cnt == '1 ? pass_cnt : pass_cnt + 1'b1;
          retry    <= '0;
        end
        if (fail_evt && can_retry) retry <= retry + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_tvbg_sequencer.sv
// tb_tvbg_sequencer: directed session scenarios against a small behavioural core model
module tb_tvbg_sequencer;
  logic clk = 1'b0, rst = 1'b1, button_n = 1'b1, busy = 1'b0, fail = 1'b0;
  logic core_start, core_reset, active_led, fail_led;
  logic [2:0] state;
  logic [3:0] pass;
  int checks = 0, failures = 0, n_start = 0, mode = 0, left = 0;
  int dt, base, hi;
  bit first = 1'b0, fail_this = 1'b0;
  always #5 clk = ~clk;
  tvbg_sequencer #(
    .DEBOUNCE_CYCLES(4), .REPEAT_COUNT(2), .GAP_CYCLES(10), .MAX_RETRY(1), .START_TIMEOUT_CYCLES(8)
  ) dut (
    .clock_in(clk), .reset_in(rst), .button_n_in(button_n),
    .core_start_out(core_start), .core_reset_out(core_reset),
    .core_busy_in(busy), .core_fail_in(fail),
    .active_led_out(active_led), .fail_led_out(fail_led),
    .state_out(state), .pass_out(pass)
  );
  // core model: mode 0 ok, 1 first attempt fails at busy fall, 2 never busy, 3 first pass ok then hangs busy
  initial forever begin
    @(negedge clk);
    if (core_reset) begin
      left = 0; busy = 1'b0; fail = 1'b0;
    end else if (core_start && mode != 2) begin
      fail = 1'b0;
      fail_this = mode == 1 && first;
      left = (mode == 3 && !first) ? 1000 : 20;
      first = 1'b0;
    end
    if (left > 0) begin
      busy = 1'b1; left--;
    end else if (busy) begin
      busy = 1'b0; fail = fail_this;
    end
  end
  initial forever begin
    @(posedge clk);
    if (core_start === 1'b1) n_start++;
  end
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic wait_for(input bit rst_pulse, output int d);
    d = 0;
    do begin
      @(negedge clk);
      d++;
    end while (!(rst_pulse ? core_reset : core_start) && d < 60);
    if (!(rst_pulse ? core_reset : core_start)) d = -1;
  endtask
  initial begin
    cycles(3);
    check("rst_state", state, 0);
    check("rst_start", core_start, 0);
    check("rst_core_reset", core_reset, 0);
    check("rst_active", active_led, 0);
    check("rst_fail", fail_led, 0);
    check("rst_pass", pass, 0);
    rst = 1'b0;
    cycles(2);
    check("idle_state", state, 0);
    base = n_start;
    for (int i = 0; i < 4; i++) begin
      button_n = i[0];
      cycles(2);
    end
    check("bounce_quiet", n_start, base);
    button_n = 1'b0;
    wait_for(1'b0, dt);
    check("press_latency", dt, 8);
    button_n = 1'b1;
    wait_for(1'b0, dt);
    check("pass_gap", dt, 31);
    cycles(25);
    check("ok_state", state, 0);
    check("ok_pass", pass, 2);
    check("ok_active", active_led, 0);
    check("ok_fail", fail_led, 0);
    check("ok_starts", n_start, base + 2);
    mode = 1; first = 1'b1; base = n_start;
    button_n = 1'b0;
    wait_for(1'b0, dt);
    check("retry_press", dt, 8);
    button_n = 1'b1;
    wait_for(1'b0, dt);
    check("retry_gap", dt, 31);
    wait_for(1'b0, dt);
    check("retry_pass2", dt, 31);
    cycles(25);
    check("retry_state", state, 0);
    check("retry_pass", pass, 2);
    check("retry_fail", fail_led, 0);
    check("retry_starts", n_start, base + 3);
    mode = 2;
    button_n = 1'b0;
    wait_for(1'b0, dt);
    check("tmo_press", dt, 8);
    button_n = 1'b1;
    wait_for(1'b0, dt);
    check("tmo_retry", dt, 19);
    cycles(10);
    check("tmo_state", state, 6);
    check("tmo_fail", fail_led, 1);
    check("tmo_active", active_led, 0);
    mode = 3; first = 1'b1;
    button_n = 1'b0;
    wait_for(1'b0, dt);
    check("err_press", dt, 8);
    check("err_clear", fail_led, 0);
    check("err_start_state", state, 1);
    button_n = 1'b1;
    wait_for(1'b0, dt);
    check("abort_pass2", dt, 31);
    cycles(5);
    check("abort_run", state, 3);
    button_n = 1'b0;
    wait_for(1'b1, dt);
    check("abort_latency", dt, 8);
    check("abort_state", state, 5);
    button_n = 1'b1;
    hi = 0;
    do begin
      hi++;
      @(negedge clk);
    end while (core_reset && hi < 10);
    check("abort_width", hi, 2);
    check("abort_idle", state, 0);
    check("abort_pass", pass, 1);
    check("abort_fail", fail_led, 0);
    base = n_start;
    cycles(40);
    check("abort_quiet", n_start, base);
    mode = 0;
    button_n = 1'b0;
    wait_for(1'b0, dt);
    check("gap_press", dt, 8);
    button_n = 1'b1;
    cycles(25);
    check("gap_state", state, 4);
    check("gap_pass", pass, 1);
    rst = 1'b1;
    cycles(1);
    check("mid_rst_state", state, 0);
    check("mid_rst_start", core_start, 0);
    check("mid_rst_core_reset", core_reset, 0);
    check("mid_rst_active", active_led, 0);
    check("mid_rst_fail", fail_led, 0);
    check("mid_rst_pass", pass, 0);
    rst = 1'b0;
    base = n_start;
    cycles(40);
    check("mid_rst_quiet", n_start, base);
    check("mid_rst_idle", state, 0);
    button_n = 1'b0;
    wait_for(1'b0, dt);
    check("post_rst_press", dt, 8);
    button_n = 1'b1;
    cycles(5);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/tvbg_sequencer.md
Name: tvbg_sequencer

Overview:
- Session controller between the board button and the tv_b_gone core.
- Debounces the raw active-low button and issues single-cycle start pulses to the core.
- Repeats the full code sequence REPEAT_COUNT times per press, with a quiet gap between passes.
- Retries failed passes, aborts on a second press (core reset), and drives the active/fail LEDs plus trace state.

Parameters:
- DEBOUNCE_CYCLES, 80000: consecutive stable cycles required to accept a new button level (10 ms at 8 MHz).
- REPEAT_COUNT, 2: full passes per session, min 1.
- GAP_CYCLES, 800000: idle cycles between passes and before a retry (100 ms), min 1.
- MAX_RETRY, 1: extra attempts per pass after a core failure.
- START_TIMEOUT_CYCLES, 16: cycles allowed for core_busy_in to rise after a start pulse.

Ports:
- clock_in  in  1  system clock (8 MHz)
- reset_in  in  1  synchronous reset, active-high
- button_n_in  in  1  raw button, active-low, asynchronous
- core_start_out  out  1  one-cycle start pulse to core
- core_reset_out  out  1  synchronous abort reset to core
- core_busy_in  in  1  core running
- core_fail_in  in  1  core failure flag
- active_led_out  out  1  high while a session is in progress
- fail_led_out  out  1  latched session failure
- state_out  out  3  current state encoding, for trace pins
- pass_out  out  4  passes completed in current session (saturates at 15)

Behaviour:
- Reset: state IDLE. All outputs 0. All counters 0. Debounced level = released. Reset mid-session behaves identically, with no core_reset_out pulse.
- Button path:
  - 2-flop synchronizer, then inversion.
  - Debounced level updates after DEBOUNCE_CYCLES consecutive cycles of a differing synchronized level; any glitch restarts the count.
  - press event = one-cycle pulse on the debounced released->pressed edge. Release generates nothing.
- States, encoding fixed: IDLE=0, START=1, WAIT_BUSY=2, RUN=3, GAP=4, ABORT=5, ERROR=6.
- IDLE / ERROR:
  - press -> START. Clears fail_led_out, pass_out and the retry count.
  - ERROR holds fail_led_out=1 until that press.
- START: core_start_out=1 for exactly this one cycle -> WAIT_BUSY. Timeout counter cleared.
- WAIT_BUSY:
  - core_busy_in=1 -> RUN.
  - START_TIMEOUT_CYCLES elapsed with busy low -> failure handling.
- RUN, on core_busy_in falling (observed as busy=0):
  - fail=0: pass_out++, retry count cleared.
    - If passes == REPEAT_COUNT -> IDLE.
    - Else -> GAP.
  - fail=1: failure handling.
  - core_fail_in=1 while busy is still 1 is also a failure: -> ABORT path with the failure flagged.
- Failure handling:
  - retries < MAX_RETRY: retry++ -> GAP, then START of the same pass.
  - Otherwise: fail_led_out=1 -> ERROR.
- GAP: counts GAP_CYCLES cycles -> START.
- Abort:
  - press in START/WAIT_BUSY/RUN/GAP -> ABORT.
  - ABORT drives core_reset_out=1 for 2 cycles -> IDLE (or -> ERROR if entered by failure). pass_out is retained.
- active_led_out = 1 in START, WAIT_BUSY, RUN, GAP, ABORT. Registered, so it follows state with 1-cycle latency.
- Latency: button edge to core_start_out = 2 sync + DEBOUNCE_CYCLES + 2 cycles.
- Simultaneous events:
  - Press in the same cycle as busy falling: abort wins.
  - Press and reset: reset wins.
  - Timeout and busy rising in the same cycle: busy wins.
- Counter widths are $clog2(param+1). Gap and timeout counters are down-counters loaded on state entry.

Decomposition:
- tvbg_pkg holds:
  - state_t enum (3-bit, encodings above);
  - ABORT_RESET_CYCLES=2 constant;
  - PASS_W=4 constant.
- Sub-module tvbg_debounce contains the synchronizer, debounce counter and press-pulse generation. Parameter: DEBOUNCE_CYCLES. Ports: clock_in, reset_in, button_n_in, pressed_out, press_out.

Test Plan (bench params: DEBOUNCE_CYCLES=4, GAP_CYCLES=10, REPEAT_COUNT=2, MAX_RETRY=1, START_TIMEOUT_CYCLES=8):
- Bounce button 0/1 every 2 cycles, then hold low 10 cycles -> exactly one core_start_out pulse, 8 cycles after the last edge. No pulse during bounce.
- Press; model busy high 20 cycles per start, fail=0 -> two start pulses separated by a 10-cycle gap. pass_out ends at 2, state IDLE, active_led_out low, fail_led_out 0.
- Press; first pass asserts fail at busy fall, second attempt succeeds -> three start pulses total, fail_led_out stays 0, pass_out=2.
- Press; core never raises busy -> timeout after 8 cycles, retry start after the gap, second timeout. fail_led_out=1, state ERROR=6. Next press clears fail_led_out.
- Press; second press during RUN -> core_reset_out high exactly 2 cycles, then IDLE. No further start pulses. pass_out retained.
- Assert reset_in for 1 cycle during GAP -> next cycle all outputs 0, state_out=0, no start pulse until a new debounced press.
